// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU operation codes, the
// multiplier FSM encoding, the EX/MEM register layout and the forwarding
// match helper.
package ex_stage_pkg;

   localparam int unsigned DataW = 32;
   localparam int unsigned RegW  = 5;

   typedef enum logic [2:0] {
      AluAdd = 3'b000,
      AluSub = 3'b001,
      AluAnd = 3'b010,
      AluOr  = 3'b011,
      AluSlt = 3'b100,
      AluNor = 3'b101,
      AluXor = 3'b110,
      AluMul = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      MulIdle = 2'b00,
      MulBusy = 2'b01,
      MulDone = 2'b10
   } mul_state_e;

   // Counter value of the final shift-add step (32 steps, 0..31).
   localparam logic [RegW-1:0] MulLastStep = 5'd31;

   typedef struct packed {
      logic             reg_write;
      logic             mem_to_reg;
      logic             mem_read;
      logic             mem_write;
      logic [DataW-1:0] alu;
      logic [DataW-1:0] wdata;
      logic [RegW-1:0]  dst;
   } exmem_t;

   // A producer forwards only if it writes a register other than R0 and that
   // register is the one being read.
   function automatic logic fwd_hit(input logic we, input logic [RegW-1:0] dst,
                                    input logic [RegW-1:0] src);
      return we && (dst != '0) && (dst == src);
   endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, MEM/WB forwarding inputs and EX/MEM outputs of the execute
// stage. master: the surrounding pipeline; slave: ex_stage.
//   flush_in, control bits, ALUOp_in, D1/D2/imm, Rs/Rt/Rd : ID/EX entry
//   wb_RegWrite_in, wb_Rd_in, wb_data_in                  : MEM/WB writeback
//   stall_out                                             : hold ID/EX and earlier
//   *_out controls, alu_out, wdata_out, dst_out           : EX/MEM register
interface ex_stage_if #(
   parameter int unsigned WIDTH = 32
);
   logic             flush_in;
   logic             RegWrite_in;
   logic             MemToReg_in;
   logic             MemRead_in;
   logic             MemWrite_in;
   logic             ALUSrc_in;
   logic             RegDst_in;
   logic [2:0]       ALUOp_in;
   logic [WIDTH-1:0] D1_in;
   logic [WIDTH-1:0] D2_in;
   logic [WIDTH-1:0] imm_in;
   logic [4:0]       Rs_in;
   logic [4:0]       Rt_in;
   logic [4:0]       Rd_in;
   logic             wb_RegWrite_in;
   logic [4:0]       wb_Rd_in;
   logic [WIDTH-1:0] wb_data_in;

   logic             stall_out;
   logic             RegWrite_out;
   logic             MemToReg_out;
   logic             MemRead_out;
   logic             MemWrite_out;
   logic [WIDTH-1:0] alu_out;
   logic [WIDTH-1:0] wdata_out;
   logic [4:0]       dst_out;

   modport master (
      output flush_in, RegWrite_in, MemToReg_in, MemRead_in, MemWrite_in, ALUSrc_in,
             RegDst_in, ALUOp_in, D1_in, D2_in, imm_in, Rs_in, Rt_in, Rd_in,
             wb_RegWrite_in, wb_Rd_in, wb_data_in,
      input  stall_out, RegWrite_out, MemToReg_out, MemRead_out, MemWrite_out,
             alu_out, wdata_out, dst_out
   );

   modport slave (
      input  flush_in, RegWrite_in, MemToReg_in, MemRead_in, MemWrite_in, ALUSrc_in,
             RegDst_in, ALUOp_in, D1_in, D2_in, imm_in, Rs_in, Rt_in, Rd_in,
             wb_RegWrite_in, wb_Rd_in, wb_data_in,
      output stall_out, RegWrite_out, MemToReg_out, MemRead_out, MemWrite_out,
             alu_out, wdata_out, dst_out
   );

endinterface

// File: rtl/ex_stage_mul_unit.sv
// Iterative shift-add multiplier, one step per cycle, low WIDTH bits of the
// unsigned product.
//   clk, rst : clock, synchronous active-high reset
//   flush    : abandon any operation and return to idle
//   start    : accepted only in idle; a and b are latched then
//   busy     : shift-add steps in progress
//   done     : one cycle, product valid
//   product  : accumulator
module ex_stage_mul_unit
   import ex_stage_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   mul_state_e       state_q, state_d;
   logic [RegW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= MulIdle;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      unique case (state_q)
         MulIdle: begin
            if (start) begin
               mcand_d  = a;
               mplier_d = b;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = MulBusy;
            end
         end
         MulBusy: begin
            // Multiplicand shifts left, multiplier right; bits shifted past
            // WIDTH only affect the discarded high half.
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == MulLastStep) state_d = MulDone;
         end
         MulDone: state_d = MulIdle;
         default: state_d = MulIdle;
      endcase
      if (flush) state_d = MulIdle;
   end

   assign busy    = (state_q == MulBusy);
   assign done    = (state_q == MulDone);
   assign product = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative multiplier
// and the EX/MEM pipeline register.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : ID/EX entry and MEM/WB forwarding in; stall and EX/MEM register out
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input logic       clk,
   input logic       rst,
   ex_stage_if.slave bus
);

   exmem_t           exmem_q, exmem_d;
   exmem_t           hold_q;
   logic [WIDTH-1:0] op_a, b_pre, op_b, alu_res;
   logic [RegW-1:0]  dst_sel;
   logic             is_mul, mul_start, mul_busy, mul_done, mul_idle, stall;
   logic [WIDTH-1:0] mul_product;

   // Forwarding: EX/MEM result wins over MEM/WB writeback.
   always_comb begin
      op_a = bus.D1_in;
      if (fwd_hit(exmem_q.reg_write, exmem_q.dst, bus.Rs_in)) begin
         op_a = exmem_q.alu;
      end else if (fwd_hit(bus.wb_RegWrite_in, bus.wb_Rd_in, bus.Rs_in)) begin
         op_a = bus.wb_data_in;
      end
      b_pre = bus.D2_in;
      if (fwd_hit(exmem_q.reg_write, exmem_q.dst, bus.Rt_in)) begin
         b_pre = exmem_q.alu;
      end else if (fwd_hit(bus.wb_RegWrite_in, bus.wb_Rd_in, bus.Rt_in)) begin
         b_pre = bus.wb_data_in;
      end
      op_b    = bus.ALUSrc_in ? bus.imm_in : b_pre;
      dst_sel = bus.RegDst_in ? bus.Rd_in : bus.Rt_in;
   end

   always_comb begin
      alu_res = '0;
      unique case (alu_op_e'(bus.ALUOp_in))
         AluAdd:  alu_res = op_a + op_b;
         AluSub:  alu_res = op_a - op_b;
         AluAnd:  alu_res = op_a & op_b;
         AluOr:   alu_res = op_a | op_b;
         AluSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         AluNor:  alu_res = ~(op_a | op_b);
         AluXor:  alu_res = op_a ^ op_b;
         AluMul:  alu_res = '0;  // result comes from the multiplier
         default: alu_res = '0;
      endcase
   end

   assign is_mul    = (bus.ALUOp_in == AluMul);
   assign mul_start = is_mul && !bus.flush_in;
   assign mul_idle  = !mul_busy && !mul_done;
   // The issue cycle stalls as well as the busy cycles; done releases the stall.
   assign stall     = !rst && !bus.flush_in && (mul_busy || (mul_idle && is_mul));

   ex_stage_mul_unit #(
      .WIDTH (WIDTH)
   ) u_mul_unit (
      .clk     (clk),
      .rst     (rst),
      .flush   (bus.flush_in),
      .start   (mul_start),
      .a       (op_a),
      .b       (op_b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // Controls, store data and destination of an accepted multiply, captured
   // with the forwarded operands so they stay consistent with the product.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q <= '0;
      end else if (mul_idle && mul_start) begin
         hold_q.reg_write  <= bus.RegWrite_in;
         hold_q.mem_to_reg <= bus.MemToReg_in;
         hold_q.mem_read   <= bus.MemRead_in;
         hold_q.mem_write  <= bus.MemWrite_in;
         hold_q.alu        <= '0;
         hold_q.wdata      <= b_pre;
         hold_q.dst        <= dst_sel;
      end
   end

   always_comb begin
      exmem_d = '0;  // bubble
      if (bus.flush_in || stall) begin
         exmem_d = '0;
      end else if (mul_done) begin
         exmem_d     = hold_q;
         exmem_d.alu = mul_product;
      end else begin
         exmem_d.reg_write  = bus.RegWrite_in;
         exmem_d.mem_to_reg = bus.MemToReg_in;
         exmem_d.mem_read   = bus.MemRead_in;
         exmem_d.mem_write  = bus.MemWrite_in;
         exmem_d.alu        = alu_res;
         exmem_d.wdata      = b_pre;
         exmem_d.dst        = dst_sel;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) exmem_q <= '0;
      else     exmem_q <= exmem_d;
   end

   assign bus.stall_out    = stall;
   assign bus.RegWrite_out = exmem_q.reg_write;
   assign bus.MemToReg_out = exmem_q.mem_to_reg;
   assign bus.MemRead_out  = exmem_q.mem_read;
   assign bus.MemWrite_out = exmem_q.mem_write;
   assign bus.alu_out      = exmem_q.alu;
   assign bus.wdata_out    = exmem_q.wdata;
   assign bus.dst_out      = exmem_q.dst;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus pushes hand-computed EX/MEM
// results, the monitor pops one whenever a non-bubble entry appears and also
// evaluates per-cycle stall/bubble/reset expectations set by the stimulus.
module tb_ex_stage;
   import ex_stage_pkg::*;

   typedef struct packed {
      logic [3:0]  ctrl;  // RegWrite, MemToReg, MemRead, MemWrite
      logic [31:0] alu;
      logic [31:0] wdata;
      logic [4:0]  dst;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   ex_stage_if bus ();

   ex_stage #(
      .WIDTH (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   logic exp_stall_en, exp_stall, exp_bubble, exp_reset, exp_present, end_req;

   // Monitor: sampled on the falling edge, away from the active edge.
   initial begin : monitor
      exp_t got, want;
      forever begin
         @(negedge clk);
         cyc++;
         got = {bus.RegWrite_out, bus.MemToReg_out, bus.MemRead_out, bus.MemWrite_out,
                bus.alu_out, bus.wdata_out, bus.dst_out};
         if (exp_stall_en) begin
            checks++;
            if (bus.stall_out !== exp_stall) begin
               errors++;
               $display("FAIL stall cyc=%0d got=%b want=%b", cyc, bus.stall_out, exp_stall);
            end
         end
         if (exp_bubble) begin
            checks++;
            if (got.ctrl !== 4'b0000) begin
               errors++;
               $display("FAIL bubble cyc=%0d got ctrl=%b want 0000", cyc, got.ctrl);
            end
         end
         if (exp_reset) begin
            checks++;
            if (got !== '0 || bus.stall_out !== 1'b0) begin
               errors++;
               $display("FAIL reset cyc=%0d got=%h stall=%b want all 0", cyc, got, bus.stall_out);
            end
         end
         if (exp_present) begin
            checks++;
            if ((|got.ctrl) !== 1'b1) begin
               errors++;
               $display("FAIL present cyc=%0d got ctrl=%b want non-bubble", cyc, got.ctrl);
            end
         end
         if ((|got.ctrl) === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected cyc=%0d got ctrl=%b alu=%h wdata=%h dst=%0d",
                        cyc, got.ctrl, got.alu, got.wdata, got.dst);
            end else begin
               want = sb.pop_front();
               if (got !== want) begin
                  errors++;
                  $display("FAIL exmem cyc=%0d got ctrl=%b alu=%h wdata=%h dst=%0d want ctrl=%b alu=%h wdata=%h dst=%0d",
                           cyc, got.ctrl, got.alu, got.wdata, got.dst,
                           want.ctrl, want.alu, want.wdata, want.dst);
               end
            end
         end
         if (end_req) begin
            checks++;
            if (sb.size() != 0) begin
               errors++;
               $display("FAIL drain got %0d pending results want 0", sb.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
         end
         if (cyc > 3000) begin
            checks++;
            errors++;
            $display("FAIL timeout got cyc=%0d want end before 3000", cyc);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      exp_stall_en = 1'b0;
      exp_bubble   = 1'b0;
      exp_reset    = 1'b0;
      exp_present  = 1'b0;
   endtask

   task automatic set_nop();
      bus.flush_in       = 1'b0;
      {bus.RegWrite_in, bus.MemToReg_in, bus.MemRead_in, bus.MemWrite_in} = 4'b0000;
      bus.ALUSrc_in      = 1'b0;
      bus.RegDst_in      = 1'b0;
      bus.ALUOp_in       = 3'b000;
      bus.D1_in          = '0;
      bus.D2_in          = '0;
      bus.imm_in         = '0;
      bus.Rs_in          = '0;
      bus.Rt_in          = '0;
      bus.Rd_in          = '0;
      bus.wb_RegWrite_in = 1'b0;
      bus.wb_Rd_in       = '0;
      bus.wb_data_in     = '0;
   endtask

   task automatic set_op(input logic [2:0] op, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic alusrc, input logic regdst,
                         input logic [3:0] ctrl);
      set_nop();
      bus.ALUOp_in  = op;
      bus.D1_in     = d1;
      bus.D2_in     = d2;
      bus.imm_in    = imm;
      bus.Rs_in     = rs;
      bus.Rt_in     = rt;
      bus.Rd_in     = rd;
      bus.ALUSrc_in = alusrc;
      bus.RegDst_in = regdst;
      {bus.RegWrite_in, bus.MemToReg_in, bus.MemRead_in, bus.MemWrite_in} = ctrl;
   endtask

   task automatic chk_stall(input logic v);
      exp_stall_en = 1'b1;
      exp_stall    = v;
   endtask

   task automatic expect_out(input logic [3:0] ctrl, input logic [31:0] alu,
                             input logic [31:0] wdata, input logic [4:0] dst);
      sb.push_back({ctrl, alu, wdata, dst});
   endtask

   task automatic alu_op(input logic [2:0] op, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic alusrc, input logic regdst,
                         input logic [3:0] ctrl);
      tick();
      set_op(op, d1, d2, imm, rs, rt, rd, alusrc, regdst, ctrl);
      chk_stall(1'b0);
   endtask

   task automatic issue_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] rd);
      set_op(AluMul, a, b, 32'd0, rs, rt, rd, 1'b0, 1'b1, 4'b1000);
      chk_stall(1'b1);
   endtask

   // Issue cycle, 32 busy cycles and the done cycle, ID/EX held throughout.
   task automatic full_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd);
      issue_mul(a, b, rs, rt, rd);
      for (int k = 1; k <= 32; k++) begin
         tick();
         issue_mul(a, b, rs, rt, rd);
         exp_bubble = 1'b1;
      end
      tick();
      issue_mul(a, b, rs, rt, rd);
      chk_stall(1'b0);
      exp_bubble = 1'b1;
   endtask

   initial begin : stimulus
      exp_stall_en = 1'b0;
      exp_stall    = 1'b0;
      exp_bubble   = 1'b0;
      exp_reset    = 1'b0;
      exp_present  = 1'b0;
      end_req      = 1'b0;
      rst          = 1'b1;
      set_nop();

      // Reset: a pending mul must not raise stall; outputs clear.
      tick();
      issue_mul(32'd6, 32'd7, 5'd1, 5'd2, 5'd5);
      chk_stall(1'b0);
      tick();
      exp_reset = 1'b1;
      chk_stall(1'b0);

      // Single-cycle ALU and forwarding.
      tick();
      rst = 1'b0;
      set_op(AluAdd, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 4'b1000);
      chk_stall(1'b0);
      expect_out(4'b1000, 32'd12, 32'd7, 5'd3);
      alu_op(AluAdd, 32'd4, 32'd5, 32'd0, 5'd5, 5'd6, 5'd4, 1'b0, 1'b1, 4'b1000);
      expect_out(4'b1000, 32'd9, 32'd5, 5'd4);
      // EX/MEM R4=9 beats stale MEM/WB R4=1.
      alu_op(AluSub, 32'd0, 32'd2, 32'd0, 5'd4, 5'd7, 5'd8, 1'b0, 1'b1, 4'b1000);
      bus.wb_RegWrite_in = 1'b1;
      bus.wb_Rd_in       = 5'd4;
      bus.wb_data_in     = 32'd1;
      expect_out(4'b1000, 32'd7, 32'd2, 5'd8);
      // MEM/WB forward on B; store data is the forwarded value.
      alu_op(AluOr, 32'h0000_000F, 32'd0, 32'd0, 5'd11, 5'd10, 5'd12, 1'b0, 1'b1, 4'b1000);
      bus.wb_RegWrite_in = 1'b1;
      bus.wb_Rd_in       = 5'd10;
      bus.wb_data_in     = 32'h0000_00F0;
      expect_out(4'b1000, 32'h0000_00FF, 32'h0000_00F0, 5'd12);
      // Immediate B, but wdata takes the EX/MEM-forwarded Rt value; dst = Rt.
      alu_op(AluAnd, 32'hFF00_FF00, 32'h0000_1234, 32'h0FF0_0FF0, 5'd13, 5'd12, 5'd29, 1'b1,
             1'b0, 4'b0001);
      expect_out(4'b0001, 32'h0F00_0F00, 32'h0000_00FF, 5'd12);
      // Write to R0, then read R0: no forwarding from either source.
      alu_op(AluXor, 32'hAAAA_0000, 32'h0000_AAAA, 32'd0, 5'd14, 5'd15, 5'd0, 1'b0, 1'b1,
             4'b1000);
      expect_out(4'b1000, 32'hAAAA_AAAA, 32'h0000_AAAA, 5'd0);
      alu_op(AluSlt, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 5'd16, 5'd17, 1'b0, 1'b1, 4'b1000);
      bus.wb_RegWrite_in = 1'b1;
      bus.wb_Rd_in       = 5'd0;
      bus.wb_data_in     = 32'd5;
      expect_out(4'b1000, 32'd1, 32'd1, 5'd17);
      alu_op(AluSlt, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd18, 5'd19, 5'd20, 1'b0, 1'b1, 4'b1000);
      expect_out(4'b1000, 32'd0, 32'hFFFF_FFFF, 5'd20);
      alu_op(AluNor, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'd0, 5'd21, 5'd22, 5'd23, 1'b0, 1'b1,
             4'b1000);
      expect_out(4'b1000, 32'hF000_F000, 32'h00FF_00FF, 5'd23);
      alu_op(AluSub, 32'd0, 32'd1, 32'd0, 5'd24, 5'd25, 5'd26, 1'b0, 1'b1, 4'b1000);
      expect_out(4'b1000, 32'hFFFF_FFFF, 32'd1, 5'd26);
      alu_op(AluAdd, 32'hFFFF_FFFF, 32'h0000_0055, 32'd2, 5'd27, 5'd28, 5'd29, 1'b1, 1'b0,
             4'b1100);
      expect_out(4'b1100, 32'd1, 32'h0000_0055, 5'd28);

      // Multiply 6x7, then a back-to-back multiply in the following idle cycle.
      tick();
      full_mul(32'd6, 32'd7, 5'd1, 5'd2, 5'd5);
      expect_out(4'b1000, 32'd42, 32'd7, 5'd5);
      tick();
      full_mul(32'hFFFF_FFFF, 32'd2, 5'd3, 5'd4, 5'd6);
      exp_present = 1'b0;
      expect_out(4'b1000, 32'hFFFF_FFFE, 32'd2, 5'd6);
      tick();
      set_nop();
      chk_stall(1'b0);
      exp_present = 1'b1;

      // Flush at busy cycle 10.
      tick();
      issue_mul(32'd3, 32'd5, 5'd1, 5'd2, 5'd7);
      for (int k = 1; k <= 9; k++) begin
         tick();
         issue_mul(32'd3, 32'd5, 5'd1, 5'd2, 5'd7);
         exp_bubble = 1'b1;
      end
      tick();
      issue_mul(32'd3, 32'd5, 5'd1, 5'd2, 5'd7);
      bus.flush_in = 1'b1;
      chk_stall(1'b0);
      exp_bubble = 1'b1;
      alu_op(AluAdd, 32'd100, 32'd23, 32'd0, 5'd7, 5'd8, 5'd9, 1'b0, 1'b1, 4'b1000);
      exp_bubble = 1'b1;
      expect_out(4'b1000, 32'd123, 32'd23, 5'd9);
      for (int k = 0; k < 40; k++) begin
         tick();
         set_nop();
         chk_stall(1'b0);
      end

      // Reset at busy cycle 5.
      tick();
      issue_mul(32'd9, 32'd9, 5'd1, 5'd2, 5'd10);
      for (int k = 1; k <= 4; k++) begin
         tick();
         issue_mul(32'd9, 32'd9, 5'd1, 5'd2, 5'd10);
         exp_bubble = 1'b1;
      end
      tick();
      issue_mul(32'd9, 32'd9, 5'd1, 5'd2, 5'd10);
      rst = 1'b1;
      chk_stall(1'b0);
      tick();
      rst = 1'b0;
      set_op(AluAdd, 32'd20, 32'd22, 32'd0, 5'd11, 5'd12, 5'd13, 1'b0, 1'b1, 4'b1000);
      exp_reset = 1'b1;
      expect_out(4'b1000, 32'd42, 32'd22, 5'd13);
      tick();
      set_nop();
      chk_stall(1'b0);
      exp_present = 1'b1;
      for (int k = 0; k < 40; k++) begin
         tick();
         set_nop();
         chk_stall(1'b0);
      end

      tick();
      end_req = 1'b1;
   end

endmodule
